// File: rtl/ksa_pkg.sv
// Shared types and default sizing for the multi-precision KSA sequencer.
package ksa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ksa_seq_state_t;

  localparam int unsigned N_DEF     = 4;
  localparam int unsigned WORDS_DEF = 4;

endpackage

// File: rtl/ksa_mp_seq_if.sv
// Operand/result handshake bundle for ksa_mp_seq.
//   request : in_valid/in_ready, a, b, cin, sub
//   response: out_valid/out_ready, sum, cout, ovf
//   status  : busy
// master = operand producer / result consumer, slave = the sequencer.
interface ksa_mp_seq_if
  import ksa_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned WORDS = WORDS_DEF
);
  localparam int unsigned W = N * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );

endinterface

// File: rtl/ksa.sv
// N-bit combinational Kogge-Stone adder slice.
//   a, b : addends      cin  : carry in
//   s    : sum          cout : carry out of bit N-1
module ksa #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  localparam int unsigned LVLS = (N > 1) ? $clog2(N) : 1;

  // g/p at level l hold group generate/propagate over bits [i : i-2^l+1]
  logic [N-1:0] g [LVLS+1];
  logic [N-1:0] p [LVLS+1];
  logic [N:0]   c;

  // Prefix tree, then fold cin in as the generate of bit -1
  always_comb begin
    g[0] = a & b;
    p[0] = a ^ b;
    for (int l = 0; l < int'(LVLS); l++) begin
      g[l+1] = g[l];
      p[l+1] = p[l];
      for (int i = (1 << l); i < int'(N); i++) begin
        g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(1<<l)]);
        p[l+1][i] = p[l][i] & p[l][i-(1<<l)];
      end
    end
    c[0] = cin;
    for (int i = 0; i < int'(N); i++) begin
      c[i+1] = g[LVLS][i] | (p[LVLS][i] & cin);
    end
    s    = p[0] ^ c[N-1:0];
    cout = c[N];
  end

endmodule

// File: rtl/ksa_mp_seq.sv
// Multi-precision add/subtract sequencer: walks W = N*WORDS-bit operands
// through one shared N-bit ksa slice, LSB slice first, carry chained in a
// register. Result, carry-out and signed overflow are held until accepted.
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : ksa_mp_seq_if.slave (request/response handshakes, busy)
module ksa_mp_seq
  import ksa_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned WORDS = WORDS_DEF
) (
  input  logic         clk,
  input  logic         reset,
  ksa_mp_seq_if.slave  bus
);

  localparam int unsigned W  = N * WORDS;
  localparam int unsigned CW = $clog2(WORDS);

  ksa_seq_state_t state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   sum_q, sum_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;
  logic           out_valid_q, out_valid_d;
  logic           in_ready_q, in_ready_d;
  logic           busy_q, busy_d;

  logic [N-1:0]   ks_s;
  logic           ks_cout;
  logic           last_c;

  // Shared slice adder fed from the low slice of the operand shifters
  ksa #(.N(N)) u_ksa (
    .a    (a_q[N-1:0]),
    .b    (b_q[N-1:0]),
    .cin  (carry_q),
    .s    (ks_s),
    .cout (ks_cout)
  );

  assign last_c = (cnt_q == CW'(WORDS - 1));

  // State register and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = {ks_s, sum_q[W-1:N]};
        a_d     = {N'(0), a_q[W-1:N]};
        b_d     = {N'(0), b_q[W-1:N]};
        carry_d = ks_cout;
        if (last_c) begin
          // Low slice now holds the MSB slice, so its top bits are the signs
          cout_d  = ks_cout;
          ovf_d   = (a_q[N-1] == b_q[N-1]) && (ks_s[N-1] != a_q[N-1]);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/ksa_mp_seq.md
# ksa_mp_seq

Multi-precision add/subtract sequencer built around one shared N-bit Kogge-Stone adder slice (`ksa`). It accepts W = N*WORDS-bit operands over a valid/ready handshake and walks them through the single `ksa` instance one N-bit slice per cycle, LSB slice first, chaining carry in a register. It returns the W-bit result, carry-out and signed overflow over a second valid/ready handshake. The block is the sequencing controller that lets a narrow adder serve wide arithmetic.

## Interface
- `N`, 4: slice width, passed to the `ksa` instance.
- `WORDS`, 4: number of slices, minimum 2; W = N*WORDS.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `in_valid`  in  1  operand request.
- `in_ready`  out  1  block can accept; equals (state == IDLE).
- `a`  in  W  operand A.
- `b`  in  W  operand B.
- `cin`  in  1  carry-in for add; ignored when `sub`=1.
- `sub`  in  1  0: A+B+cin; 1: A−B (A + ~B + 1).
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `sum`  out  W  result.
- `cout`  out  1  carry-out of the MSB slice; for subtract, 1 means no borrow.
- `ovf`  out  1  signed two's-complement overflow.
- `busy`  out  1  state != IDLE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`, capture `a`, `b` (inverted if `sub`) and `sub` into shift registers.
  - Load the carry register with `sub ? 1 : cin`, clear the slice counter, go to RUN.
- RUN, slice k (k = 0..WORDS−1):
  - `ksa` inputs are the low N bits of the A/B shift registers plus the carry register.
  - Each edge:
    - Shift the `ksa` `s` output into the top of the sum shift register.
    - Shift the A/B registers right by N.
    - Load `ksa` `cout` into the carry register.
    - Increment the counter.
  - After the edge that processes k = WORDS−1, go to DONE.
- DONE:
  - `out_valid`=1. `sum`, `cout` and `ovf` are stable and unchanged until the handshake.
  - On `out_valid && out_ready`, go to IDLE.
- `ovf` = (A[W−1] == B'[W−1]) && (sum[W−1] != A[W−1]), where B' is the possibly inverted B. The MSB-slice operand bits are captured during the last RUN cycle.
- Counter width: $clog2(WORDS), with no wrap-around beyond WORDS−1. The RUN→DONE transition is decided on counter == WORDS−1.
- The `ksa` instance is combinational. No other arithmetic sits in the datapath.

## Timing
- Accept on edge 0. Slices are computed on edges 1..WORDS. `out_valid` rises after edge WORDS.
- With `out_ready` held high: the output handshake happens at edge WORDS+1 and `in_ready` rises after it. Throughput is one operation per WORDS+2 edges.
- No input/output overlap: `in_ready`=0 in RUN and DONE. `in_valid` in those states is ignored and does not queue.
- `out_ready` outside DONE has no effect.
- Reset values:
  - State is IDLE, so `in_ready`=1 and `busy`=0.
  - `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0.
  - Counter, carry and shift registers are 0.
- Reset asserted mid-RUN or in DONE: the operation is discarded and outputs return to reset values immediately (asynchronously). No result is ever presented for that operation.
- Inputs must be stable only in the accept cycle.

## Structure
- Package `ksa_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} ksa_seq_state_t`.
  - Default localparams N_DEF=4 and WORDS_DEF=4.
- Sub-module: one instance of the existing `ksa` (ports `a`, `b`, `cin`, `s`, `cout`). No other sub-modules.
- Shift registers, counter, carry register and FSM live in `ksa_mp_seq`.

## Test plan
All scenarios use N=4, WORDS=4 (W=16). Every check compares `sum`, `cout` and `ovf` with `!==`.

1. Add: a=16'h1234, b=16'h4321, cin=0, sub=0 → sum=16'h5555, cout=0, ovf=0. `out_valid` rises exactly 4 edges after accept.
2. Carry chain: a=16'hFFFF, b=16'h0001, cin=0 → sum=16'h0000, cout=1, ovf=0. The carry propagates through all 4 slices.
3. Subtract: a=16'h0005, b=16'h0007, sub=1, cin=1 (ignored) → sum=16'hFFFE, cout=0, ovf=0.
4. Signed overflow: a=16'h7FFF, b=16'h0001, add → sum=16'h8000, cout=0, ovf=1.
5. Backpressure: hold `out_ready`=0 for 5 cycles in DONE, with `in_valid`=1 and new operands driven.
   - Required: `sum` stable, `in_ready`=0, new request not accepted.
   - Release `out_ready`: handshake happens, and the next accept occurs only after `in_ready`=1.
6. Reset during RUN (slice 2): `out_valid` stays 0 and all outputs read reset values. After release, op 1 repeated yields 16'h5555.
